// File: rtl/sorted_memory.sv
// Sorted memory responder for the binary search engine.
// Holds up to memory_size unsigned values in ascending order. Values are added
// through a valid/ready port, and an insertion sort moves larger entries up by
// one slot per cycle. Slots that hold no value read as all-ones, so a search
// over the full address range still works when the memory is only partly filled.
//
// state | meaning
// IDLE  | waiting for an insert; ins_ready is high unless the memory is full
// SHIFT | insertion in progress; one entry moves up one slot per cycle
module sorted_memory #(
    parameter int number_size = 8,
    parameter int index_size  = 4,
    parameter int memory_size = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ins_valid,
    input  logic [number_size-1:0] ins_data,
    output logic                   ins_ready,
    input  logic                   clear,
    input  logic [index_size-1:0]  read_address,
    output logic [number_size-1:0] read_data,
    output logic [index_size:0]    count,
    output logic                   full,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [number_size-1:0] ALL_ONES = '1;
    localparam logic [index_size:0]    MEM_SIZE = (index_size + 1)'(memory_size);

    state_t                 state_q, state_d;
    logic [number_size-1:0] mem_q [memory_size];
    logic [number_size-1:0] mem_d [memory_size];
    logic [index_size:0]    ptr_q, ptr_d;
    logic [index_size:0]    count_q, count_d;
    logic [number_size-1:0] new_val_q, new_val_d;
    logic [number_size-1:0] prev_val;

    assign count     = count_q;
    assign full      = (count_q == MEM_SIZE);
    assign busy      = (state_q == SHIFT);
    assign ins_ready = (state_q == IDLE) && !full && !clear;

    // Combinational read port; out-of-range addresses fall through to all-ones
    always_comb begin
        read_data = ALL_ONES;
        for (int i = 0; i < memory_size; i++) begin
            if (read_address == index_size'(i)) begin
                read_data = mem_q[i];
            end
        end
    end

    // Entry just below the insertion pointer, the one compared against new_val
    always_comb begin
        prev_val = ALL_ONES;
        for (int i = 0; i < memory_size; i++) begin
            if (ptr_q == (index_size + 1)'(i + 1)) begin
                prev_val = mem_q[i];
            end
        end
    end

    // Next-state logic: clear overrides both accepting and shifting
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        new_val_d = new_val_q;
        mem_d     = mem_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            for (int i = 0; i < memory_size; i++) begin
                mem_d[i] = ALL_ONES;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ins_valid && ins_ready) begin
                        new_val_d = ins_data;
                        ptr_d     = count_q;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    // Stop on "<=" so the new value lands after equal entries
                    if ((ptr_q == '0) || (prev_val <= new_val_q)) begin
                        for (int i = 0; i < memory_size; i++) begin
                            if (ptr_q == (index_size + 1)'(i)) begin
                                mem_d[i] = new_val_q;
                            end
                        end
                        count_d = count_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        for (int i = 0; i < memory_size; i++) begin
                            if (ptr_q == (index_size + 1)'(i)) begin
                                mem_d[i] = prev_val;
                            end
                        end
                        ptr_d = ptr_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pointer, count and storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            new_val_q <= '0;
            for (int i = 0; i < memory_size; i++) begin
                mem_q[i] <= ALL_ONES;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            new_val_q <= new_val_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: doc/sorted_memory.md
Name: sorted_memory

Overview:
- Memory-side responder for the binary search engine. It holds up to memory_size unsigned numbers in ascending order and serves the engine's combinational read port (memory_address -> memory_in).
- Values are loaded one at a time through a valid/ready insert port. An insertion-sort FSM shifts larger entries up one slot per cycle and drops the new value into place.
- Unfilled slots read as all-ones, so a search over the full address range stays correct on a partly filled memory.

Parameters:
- number_size, 8: width of each stored number; must match the search engine.
- index_size, 4: width of read_address; 2**index_size >= memory_size.
- memory_size, 16: number of storage entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ins_valid  in  1  insert request; ins_data is valid while high.
- ins_data  in  number_size  value to insert (unsigned).
- ins_ready  out  1  high when an insert can be accepted.
- clear  in  1  synchronous empty command.
- read_address  in  index_size  read index, driven by search memory_address.
- read_data  out  number_size  entry at read_address, combinational; drives search memory_in.
- count  out  index_size+1  number of valid entries, 0..memory_size.
- full  out  1  count == memory_size.
- busy  out  1  insertion in progress; read_data may show a partly shifted array.

Behaviour:
- Reset (rst low, async):
  - state IDLE, count 0, busy 0, full 0.
  - All entries all-ones; ins_ready 1 once rst is released.
- read_data:
  - Equals mem[read_address] with zero-cycle latency, in any state.
  - read_address >= memory_size returns all-ones.
- ins_ready = (state==IDLE) && !full && !clear, combinational.
- Accept when ins_valid && ins_ready at a rising edge:
  - Latch new_val <= ins_data, ptr <= count, state <= SHIFT, busy <= 1.
- SHIFT state, one cycle per step:
  - If ptr==0 or mem[ptr-1] <= new_val: mem[ptr] <= new_val, count <= count+1, state <= IDLE, busy <= 0.
  - Otherwise: mem[ptr] <= mem[ptr-1], ptr <= ptr-1, stay in SHIFT.
- Latency:
  - Insert takes k+1 cycles after acceptance, where k is the number of stored entries strictly greater than new_val.
  - Best case 1 cycle, worst case count+1 cycles.
  - count updates on the final SHIFT cycle; the next insert can be accepted the cycle after.
- Duplicates: the new value goes after existing equal entries (stable); count increments normally.
- Value all-ones is legal; it lands at index count, which is indistinguishable from empty padding but is counted.
- Full: ins_ready low. ins_valid held high is not accepted and has no effect. No overwrite, no wrap-around.
- clear, sampled at the rising edge:
  - Effect: count <= 0, all entries <= all-ones, state <= IDLE, busy <= 0.
  - Takes priority over everything, including an insertion in progress (aborted, value discarded) and a same-cycle ins_valid (not accepted).
- Async reset mid-insertion: identical to the reset state; the partial shift is discarded.
- Comparisons are unsigned number_size-bit. ptr and count are index_size+1 bits; no overflow is possible because insertion is blocked when full.
- Reads during busy are not blocked. The search engine is started only when busy==0; violating this is a system error, not handled here.

Test Plan:
- Reset then insert 5, 3, 9, 3 with idle gaps -> count=4; reads 0..4 = 3, 3, 5, 9, 8'hFF. Insert of 9 takes 1 cycle; second 3 takes 3 cycles (shifts 9 and 5).
- Reverse order 15..0, memory_size=16 -> each insert takes count+1 cycles. Final mem[i]=i, full=1, ins_ready=0. A 17th ins_valid (value 7) is ignored and the array is unchanged.
- Back-to-back: ins_valid held high with 4, then 2 presented right after acceptance -> 2 is accepted only on the cycle after busy falls. Final order 2, 4.
- clear asserted on the 2nd SHIFT cycle of inserting 1 into {2, 6, 8} -> next cycle count=0, busy=0, all reads 8'hFF. ins_valid in the clear cycle is not accepted.
- Async reset pulse mid-shift, between clock edges -> outputs go to reset values immediately, with no clock edge needed.
- Integration with binary_search: fill {1, 4, 7, 10}, search target 7 -> out=2; target 5 -> out=all-ones (-1).
